// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the memory stage and a word-wide single-port RAM.
// Loads are returned sign- or zero-extended. Byte and halfword stores become read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses are rejected with
// rsp_err. Without it, the offending low address bits are cleared and the access proceeds.
module lsu_align #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_wdata,
  output logic              mem_we
);
  typedef enum logic [2:0] {IDLE, RD, WT, WR, RSP} state_t;
  state_t            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              accept, legal, trap;
  logic [1:0]        off_in;
  logic [4:0]        sh;
  logic [15:0]       lane;
  logic [31:0]       load_ext, merged;
  logic              unused_addr;
  // Address bits above the RAM size alias by design.
  assign unused_addr = ^req_addr[31:ADDR_W];
  // Classify the incoming request and pick its effective lane offset.
  always_comb begin
    accept = req_valid && (state_q == IDLE);
    legal  = req_store ? (req_funct3 <= 3'd2) : (req_funct3 != 3'd3 && req_funct3 <= 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    trap   = legal && ((req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0));
    off_in = req_addr[1:0];
`else
    trap   = 1'b0;
    off_in = req_funct3[1] ? 2'd0 : req_funct3[0] ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif
  end
  // Extract and extend the load lane, and merge store data into the read word.
  always_comb begin
    sh       = {off_q, 3'b000};
    lane     = 16'(mem_rdata >> sh);
    load_ext = f3_q[1] ? mem_rdata :
               f3_q[0] ? {{16{~f3_q[2] & lane[15]}}, lane} :
                         {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
    merged   = f3_q[0] ? ((mem_rdata & ~(32'h0000_FFFF << sh)) | ({16'd0, wdata_q} << sh)) :
                         ((mem_rdata & ~(32'h0000_00FF << sh)) | ({24'd0, wdata_q[7:0]} << sh));
  end
  // Next state, latched request fields, and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d    = f3_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = (!legal || trap) ? RSP : (req_store && req_funct3[1]) ? WR : RD;
        store_d = req_store;
        f3_d    = req_funct3;
        off_d   = off_in;
        wdata_d = req_wdata[15:0];
      end
      RD:      state_d = WT;
      WT:      state_d = store_q ? WR : RSP;
      WR:      state_d = RSP;
      default: state_d = IDLE;
    endcase
    mem_we_d    = state_d == WR;
    rsp_valid_d = state_d == RSP;
    rsp_err_d   = state_q == IDLE && state_d == RSP;
    rsp_rdata_d = (state_q == WT && !store_q) ? load_ext : 32'd0;
    mem_addr_d  = (state_q == IDLE && (state_d == RD || state_d == WR)) ?
                  {req_addr[ADDR_W-1:2], 2'b00} : mem_addr_q;
    mem_wdata_d = (state_q == IDLE && state_d == WR) ? req_wdata :
                  (state_q == WT && store_q) ? merged : mem_wdata_q;
  end
  // State and output registers; reset aborts any transaction and drops mem_we at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      wdata_q     <= 16'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: randomized and directed bench for lsu_align against a byte-level reference model.
module tb_lsu_align;
  localparam int ADDR_W = 14;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_store = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              req_ready, rsp_valid, rsp_err, mem_we;
  logic [31:0]       rsp_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       ram   [4096];
  logic [31:0]       model [4096];
  int                n_tests = 0;
  int                n_fail = 0;

  lsu_align #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[ADDR_W-1:2]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[ADDR_W-1:2]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input int off);
    int nb = 1 << f3[1:0];
    logic [31:0] v = 32'd0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
    if (!f3[2] && nb < 4 && v[8*nb-1])
      for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [2:0] f3, input int off);
    int nb = 1 << f3[1:0];
    logic [31:0] r = w;
    for (int i = 0; i < nb; i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic chk_rst();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
  endtask

  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] got_r);
    logic        legal, mis, err, rerr;
    int          nb, off, idx, rk, wk, nr, nw;
    logic [31:0] erd, ewd, rd, wdat, wad;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb    = 1 << f3[1:0];
    mis   = legal && (int'(a[1:0]) % nb) != 0;
    err   = !legal || (TRAP && mis);
    off   = err ? 0 : (int'(a[1:0]) / nb) * nb;
    idx   = int'(a[ADDR_W-1:2]);
    erd   = (!err && !st) ? ref_load(model[idx], f3, off) : 32'd0;
    ewd   = (!err && st) ? ref_store(model[idx], wd, f3, off) : 32'd0;
    @(negedge clk);
    check("ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rk = 0; wk = 0; nr = 0; nw = 0; rd = 0; rerr = 0; wdat = 0; wad = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rsp_valid) begin nr++; rk = k; rd = rsp_rdata; rerr = rsp_err; end
      if (mem_we) begin nw++; wk = k; wdat = mem_wdata; wad = 32'(mem_addr); end
    end
    check("rsp_cnt", nr, 32'd1);
    check("rsp_cyc", rk, err ? 1 : !st ? 3 : (f3 == 3'd2) ? 2 : 4);
    check("rsp_err", 32'(rerr), 32'(err));
    check("rsp_rdata", rd, erd);
    check("we_cnt", nw, (err || !st) ? 0 : 1);
    if (!err && st) begin
      check("we_cyc", wk, (f3 == 3'd2) ? 1 : 3);
      check("we_data", wdat, ewd);
      check("we_addr", wad, idx << 2);
      model[idx] = ewd;
    end
    got_r = st ? wdat : rd;
  endtask

  initial begin
    logic [31:0] r, rd;
    int          rk, idx;
    repeat (2) @(posedge clk);
    #1 chk_rst();
    @(negedge clk) resetn = 1'b1;
    txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, r);
    txn(1'b0, 3'd2, 32'h100, 32'd0, r);           check("lw_lit", r, 32'hDEADBEEF);
    txn(1'b1, 3'd2, 32'h100, 32'h80112233, r);
    txn(1'b0, 3'd0, 32'h103, 32'd0, r);           check("lb_lit", r, 32'hFFFFFF80);
    txn(1'b0, 3'd4, 32'h103, 32'd0, r);           check("lbu_lit", r, 32'h00000080);
    txn(1'b0, 3'd1, 32'h102, 32'd0, r);           check("lh_lit", r, 32'hFFFF8011);
    txn(1'b1, 3'd2, 32'h100, 32'h11223344, r);
    txn(1'b1, 3'd0, 32'h101, 32'h000000AB, r);    check("sb_lit", r, 32'h1122AB44);
    txn(1'b1, 3'd2, 32'h100, 32'h11223344, r);
    txn(1'b1, 3'd1, 32'h102, 32'h0000BEEF, r);    check("sh_lit", r, 32'hBEEF3344);
    txn(1'b1, 3'd2, 32'h100, 32'h11223344, r);
    txn(1'b1, 3'd1, 32'h101, 32'h12345566, r);
    txn(1'b0, 3'd2, 32'h100, 32'd0, r);           check("sh_mis", r, TRAP ? 32'h11223344 : 32'h11225566);
    txn(1'b0, 3'd3, 32'h100, 32'd0, r);
    txn(1'b1, 3'd4, 32'h100, 32'hFFFFFFFF, r);
    txn(1'b0, 3'd2, 32'hFFFF_C100, 32'd0, r);     check("wrap", r, TRAP ? 32'h11223344 : 32'h11225566);
    // reset in the WT state of an SB: nothing written, a held request goes on the first edge after release
    txn(1'b1, 3'd2, 32'h104, 32'h11223344, r);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h104; req_wdata = 32'hAB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk_rst();
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h104;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1 check("acc_after_rst", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    rk = 0; rd = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (rsp_valid) begin rk = k; rd = rsp_rdata; end
    end
    check("rst_rsp_cyc", rk, 32'd3);
    check("rst_ram_kept", rd, 32'h11223344);
    for (int i = 0; i < 16; i++) txn(1'b1, 3'd2, 32'h100 + 32'(4*i), $urandom, r);
    for (int n = 0; n < 300; n++) begin
      idx = 'h40 + $urandom_range(0, 15);
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          ($urandom & 32'hFFFF_C000) | 32'(idx << 2) | 32'($urandom_range(0, 3)), $urandom, r);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
